// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-port dmem arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address / data widths
//   req_id_e                : requester ids (REQ_DP = datapath, REQ_LD = loader/debug)
//   arb_state_e             : last-winner state (LAST0 / LAST1)
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    REQ_DP = 1'b0,
    REQ_LD = 1'b1
  } req_id_e;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } arb_state_e;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational grant decision for two requesters.
//   req0, req1 : requests
//   last       : requester granted most recently (LAST0 / LAST1)
//   gnt        : one-hot grant, bit index = req_id_e
// Build option MEM_ARB_FIXED_PRIO_EN: requester 0 always wins contention and
// 'last' is ignored; otherwise the requester not granted last wins.
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  arb_state_e last,
  output logic [1:0] gnt
);

  logic pick1;  // contention winner is requester 1

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick1 = 1'b0;
  logic unused_last;
  assign unused_last = last;
`else
  assign pick1 = (last == LAST0);
`endif

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt[REQ_LD] = pick1;
      gnt[REQ_DP] = !pick1;
    end else begin
      gnt[REQ_DP] = req0;
      gnt[REQ_LD] = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port dmem between the datapath (requester 0)
// and the loader/debug port (requester 1).
//   clk, reset             : clock, async active-low reset
//   reqN/weN/addrN/wdataN  : requester N access request
//   gntN                   : requester N owns the dmem port this cycle
//   rdataN/rvalidN         : read data, valid for the one cycle after a read grant
//   mem_we/addr/wdata      : shared dmem port; mem_rdata is its combinational read data
// Build option MEM_ARB_FIXED_PRIO_EN (see rr_pick): fixed priority to requester 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q, state_d;
  logic [1:0] pick;

  rr_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (state_q),
    .gnt  (pick)
  );

  // Gating with reset makes grants and mem_we drop the moment reset asserts,
  // so an in-flight write never lands on the edge that would have ended it.
  assign gnt0 = pick[REQ_DP] & reset;
  assign gnt1 = pick[REQ_LD] & reset;

  // Requester 0 is the default path so the port is quiet (apart from we) when idle.
  assign mem_we    = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addr  = gnt1 ? addr1  : addr0;
  assign mem_wdata = gnt1 ? wdata1 : wdata0;

  always_comb begin
    state_d = state_q;
    if (gnt0)      state_d = LAST0;
    else if (gnt1) state_d = LAST1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LAST1;  // requester 0 wins the first contention
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state_q <= state_d;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= mem_rdata;
      if (gnt1 && !we1) rdata1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          stamp;
  } sb_t;
  sb_t q0[$];
  sb_t q1[$];

  // dmem model: word i preloaded with 0xA0000000 + i
  logic [31:0] dmem [0:63];
  assign mem_rdata = dmem[mem_addr[7:2]];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = 32'hA000_0000 + i;
    forever begin
      @(posedge clk);
      if (mem_we) dmem[mem_addr[7:2]] = mem_wdata;
      cyc = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest expected read and arrive
  // exactly one cycle after its grant.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rvalid0) begin
        if (q0.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("rdata0", rdata0, e.data);
          chk("rvalid0_latency", cyc, e.stamp + 1);
        end
      end
      if (rvalid1) begin
        if (q1.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("rdata1", rdata1, e.data);
          chk("rvalid1_latency", cyc, e.stamp + 1);
        end
      end
    end
  end

  // One cycle: drive at posedge+1, check grants/port at negedge, queue expected reads.
  task automatic step(input string nm,
                      input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] x0,
                      input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] x1,
                      input bit e0, input bit e1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    chk({nm, "_gnt0"}, {31'd0, gnt0}, {31'd0, e0});
    chk({nm, "_gnt1"}, {31'd0, gnt1}, {31'd0, e1});
    chk({nm, "_mem_we"}, {31'd0, mem_we}, {31'd0, (e0 & w0) | (e1 & w1)});
    if (e0 || e1) chk({nm, "_mem_addr"}, mem_addr, e1 ? a1 : a0);
    if ((e0 && w0) || (e1 && w1)) chk({nm, "_mem_wdata"}, mem_wdata, e1 ? d1 : d0);
    if (e0 && !w0) q0.push_back('{x0, cyc});
    if (e1 && !w1) q1.push_back('{x1, cyc});
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // simultaneous first requests straight out of reset
    step("first_a", 1, 0, 32'h4, 0, 32'hA000_0001, 1, 0, 32'h8, 0, 32'hA000_0002, 1, 0);
    step("first_b", 0, 0, 0, 0, 0,                 1, 0, 32'h8, 0, 32'hA000_0002, 0, 1);

    // write then read on requester 0
    step("wr0", 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rd0", 1, 0, 32'h10, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1, 0);
    idle("idle_a");
    idle("idle_b");
    chk("rdata0_hold", rdata0, 32'hDEAD_BEEF);
    chk("rvalid0_single", {31'd0, rvalid0}, 32'd0);

    // requester 1 writes, requester 0 reads it back next cycle
    step("wr1", 0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678, 0, 0, 1);
    step("rd0_x", 1, 0, 32'h20, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 0);

    // leave requester 1 as last winner, then sustained contention
    step("pre_cont", 0, 0, 0, 0, 0, 1, 0, 32'h8, 0, 32'hA000_0002, 0, 1);
    for (int i = 0; i < 6; i++) begin
      bit e0;
      e0 = FIXED ? 1'b1 : (i % 2 == 0);
      step("cont", 1, 0, 32'h0, 0, 32'hA000_0000, 1, 0, 32'h4, 0, 32'hA000_0001, e0, !e0);
    end

    // requester 1 loses a write, then withdraws: dmem untouched
    step("drop_a", 1, 0, 32'h0, 0, 32'hA000_0000, 1, 1, 32'h30, 32'h5555_5555, 0, 1, 0);
    step("drop_b", 1, 0, 32'h30, 0, 32'hA000_000C, 0, 0, 0, 0, 0, 1, 0);

    // reset during a read grant to requester 1 (last winner is 0 beforehand)
    step("abort_pre", 1, 0, 32'h0, 0, 32'hA000_0000, 0, 0, 0, 0, 0, 1, 0);
    req0 = 0; req1 = 1; we1 = 0; addr1 = 32'h8;
    @(negedge clk);
    chk("abort_rd_gnt1_pre", {31'd0, gnt1}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_rd_gnt1", {31'd0, gnt1}, 32'd0);
    chk("abort_rd_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    req1 = 0;
    reset = 1'b1;
    chk("abort_rdata1", rdata1, 32'd0);
    chk("abort_rvalid1", {31'd0, rvalid1}, 32'd0);
    step("post_rst", 1, 0, 32'h4, 0, 32'hA000_0001, 1, 0, 32'h8, 0, 32'hA000_0002, 1, 0);
    step("post_rst_b", 0, 0, 0, 0, 0,              1, 0, 32'h8, 0, 32'hA000_0002, 0, 1);

    // reset during a write grant: mem_we must fall at once and the write is lost
    req1 = 1; we1 = 1; addr1 = 32'h34; wdata1 = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("abort_wr_we_pre", {31'd0, mem_we}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_wr_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    req1 = 0; we1 = 0;
    reset = 1'b1;
    step("abort_wr_chk", 1, 0, 32'h34, 0, 32'hA000_000D, 0, 0, 0, 0, 0, 1, 0);

    idle("tail_a");
    idle("tail_b");
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte address width of all address ports.
REQ-002 Parameter DATA_W, default 32: data width of all data ports.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 req0 / we0 / addr0 / wdata0  input  1/1/ADDR_W/DATA_W  requester 0 (datapath data port): access request, write enable, address, write data.
REQ-006 gnt0  output  1  access granted to requester 0 this cycle.
REQ-007 rdata0 / rvalid0  output  DATA_W/1  requester 0 read data, and its one-cycle valid pulse.
REQ-008 req1 / we1 / addr1 / wdata1  input  1/1/ADDR_W/DATA_W  requester 1 (loader/debug port): same meaning as requester 0.
REQ-009 gnt1, rdata1, rvalid1  output  1/DATA_W/1  same meaning as the requester 0 outputs.
REQ-010 mem_we / mem_addr / mem_wdata  output  1/ADDR_W/DATA_W  port driven to the shared single-port dmem.
REQ-011 mem_rdata  input  DATA_W  combinational read data from the dmem.

Function
REQ-012 Arbitration is combinational within a cycle: at most one of gnt0/gnt1 is high, and gntN is high only while reqN is high.
REQ-013 One request only: that requester is granted in the same cycle.
REQ-014 Both requesting, round-robin mode: the requester not granted last wins; the last-winner register updates on the granting edge.
REQ-015 State machine LAST0 / LAST1: a grant to 0 moves to LAST0 and a grant to 1 moves to LAST1; a cycle with no grant holds the state.
REQ-016 Memory port muxing: mem_addr, mem_wdata and mem_we follow the granted requester; with no grant, mem_we = 0 and mem_addr/mem_wdata hold the requester-0 values.
REQ-017 Write: the dmem write occurs at the rising edge that ends the grant cycle; rvalidN stays 0 for writes.
REQ-018 Read: mem_rdata is captured into rdataN at the edge ending the grant cycle, and rvalidN is high for exactly the following cycle.
REQ-019 rdataN holds its last captured value until the next read grant to that requester.
REQ-020 A requester holds reqN, weN, addrN and wdataN stable until it sees gntN; the arbiter requires no deassertion between back-to-back accesses.
REQ-021 Back-to-back contention: with both requesters continuously requesting, grants alternate 0,1,0,1... every cycle, giving full throughput and no idle cycle.
REQ-022 A requester that deasserts reqN before its grant is dropped with no side effect.

Reset
REQ-023 While reset = 0: gnt0 = gnt1 = 0, mem_we = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0, and the state is LAST1 (requester 0 wins the first contention).
REQ-024 Reset asserted mid-access aborts the access: no rvalid pulse follows, and mem_we drops immediately (asynchronously).
REQ-025 The first grant can occur in the first cycle after reset deasserts.

Configuration
REQ-026 Macro MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins contention, and the LAST0/LAST1 state is still maintained but ignored.
REQ-027 Macro MEM_ARB_FIXED_PRIO_EN undefined (default): round-robin per REQ-014.

Structure
REQ-028 Shared package mem_arb_pkg holds the ADDR_W/DATA_W defaults, the requester-id enum (REQ_DP = 0, REQ_LD = 1) and the state enum (LAST0, LAST1).
REQ-029 The grant decision is a combinational sub-module rr_pick (inputs: two requests plus last winner; output: one-hot grant); registers and muxing stay in mem_arbiter.

Verification
REQ-030 Write then read on requester 0 only: write 0xDEADBEEF to 0x10, then read 0x10 -> gnt0 in each request cycle, and rvalid0 = 1 with rdata0 = 0xDEADBEEF one cycle after the read grant.
REQ-031 Simultaneous first requests after reset (req0 read 0x4, req1 read 0x8) -> gnt0 in cycle 0 and gnt1 in cycle 1, then rvalid0 in cycle 1 and rvalid1 in cycle 2.
REQ-032 Both requesters held high for 6 cycles -> grant sequence 0,1,0,1,0,1 and mem_we never high in a cycle without a grant.
REQ-033 Requester 1 writes 0x12345678 to 0x20 while requester 0 reads 0x20 in the next cycle -> rdata0 = 0x12345678.
REQ-034 Reset pulsed low during a read grant to requester 1 -> gnt1 and mem_we are 0 immediately, no rvalid1 pulse, and the state is LAST1 after release.
REQ-035 With MEM_ARB_FIXED_PRIO_EN defined, both requesters held high for 4 cycles -> gnt0 in all 4 cycles and gnt1 never asserted.
